// File: rtl/neighbor_popcount_accumulator.sv
// Bit-serial population counter: accepts N_INPUTS single-bit cell states over a
// valid/ready handshake and presents their count with a sticky overflow flag.
module neighbor_popcount_accumulator #(
    parameter int N_INPUTS  = 8,
    parameter int SUM_WIDTH = 4,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 in_ready,
    output logic [SUM_WIDTH-1:0] sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 overflow
);

    localparam int IDX_W = $clog2(N_INPUTS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [SUM_WIDTH-1:0] ACC_MAX  = '1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_INPUTS - 1);

    logic [1:0]           state;
    logic [SUM_WIDTH-1:0] acc;
    logic [IDX_W-1:0]     idx;
    logic                 ovf;

    // Handshake outputs come from registered state only, so neither ready nor
    // valid loops back combinationally through the neighbouring blocks.
    assign in_ready  = (state == S_ACCUM);
    assign sum_valid = (state == S_HOLD);
    assign sum       = acc;
    assign overflow  = ovf;

    // NOTE: every register here is written with <= so all of them update
    // together from pre-edge values; a blocking = would leak new values forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        idx   <= '0;
                        ovf   <= 1'b0;
                    end
                end

                S_ACCUM: begin
                    if (in_valid) begin
                        idx <= idx + IDX_W'(1);
                        if (in_bit) begin
                            if (acc == ACC_MAX) begin
                                ovf <= 1'b1;
                                acc <= (SATURATE != 0) ? ACC_MAX : '0;
                            end else begin
                                acc <= acc + SUM_WIDTH'(1);
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // A START alongside the output handshake begins the next
                    // count immediately, overlapping it with the HOLD cycle.
                    if (sum_ready) begin
                        if (start) begin
                            state <= S_ACCUM;
                            acc   <= '0;
                            idx   <= '0;
                            ovf   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_popcount_accumulator.sv
// Bench for neighbor_popcount_accumulator: three parameterisations share one
// input stream; results are compared against a popcount-based reference.
module tb_neighbor_popcount_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic sum_ready = 1'b0;

    logic       ir0, ir1, ir2;
    logic       sv0, sv1, sv2;
    logic       ov0, ov1, ov2;
    logic [3:0] sum0;
    logic [1:0] sum1, sum2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neighbor_popcount_accumulator #(.N_INPUTS(8), .SUM_WIDTH(4), .SATURATE(0)) u_w4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir0), .sum(sum0), .sum_valid(sv0), .sum_ready(sum_ready), .overflow(ov0)
    );

    neighbor_popcount_accumulator #(.N_INPUTS(8), .SUM_WIDTH(2), .SATURATE(0)) u_w2_wrap (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir1), .sum(sum1), .sum_valid(sv1), .sum_ready(sum_ready), .overflow(ov1)
    );

    neighbor_popcount_accumulator #(.N_INPUTS(8), .SUM_WIDTH(2), .SATURATE(1)) u_w2_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir2), .sum(sum2), .sum_valid(sv2), .sum_ready(sum_ready), .overflow(ov2)
    );

    // Reference: the count of ones, reduced to the result width by wrap or clamp.
    function automatic int model_sum(input int ones, input int width, input bit sat);
        int max_val;
        max_val = (1 << width) - 1;
        if (sat) return (ones > max_val) ? max_val : ones;
        return ones % (1 << width);
    endfunction

    function automatic int model_ovf(input int ones, input int width);
        return (ones > (1 << width) - 1) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input int ones);
        chk("sum_w4", 32'(sum0), 32'(model_sum(ones, 4, 1'b0)));
        chk("ovf_w4", 32'(ov0), 32'(model_ovf(ones, 4)));
        chk("sum_w2_wrap", 32'(sum1), 32'(model_sum(ones, 2, 1'b0)));
        chk("ovf_w2_wrap", 32'(ov1), 32'(model_ovf(ones, 2)));
        chk("sum_w2_sat", 32'(sum2), 32'(model_sum(ones, 2, 1'b1)));
        chk("ovf_w2_sat", 32'(ov2), 32'(model_ovf(ones, 2)));
        chk("sum_valid_all", {29'd0, sv0, sv1, sv2}, 32'd7);
        chk("in_ready_hold", {29'd0, ir0, ir1, ir2}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {29'd0, ir0, ir1, ir2}, 32'd0);
        chk({tag, "_valid"}, {29'd0, sv0, sv1, sv2}, 32'd0);
        chk({tag, "_ovf"},   {29'd0, ov0, ov1, ov2}, 32'd0);
        chk({tag, "_sum"},   {24'd0, sum0, sum1, sum2}, 32'd0);
    endtask

    // Presents bits[0] first. Called at a falling edge; returns at the falling
    // edge where the result should first be visible. Stalls of stall_len cycles
    // follow the handshakes numbered stall_a and stall_b.
    task automatic run(input logic [7:0] bits, input bit do_start,
                       input int stall_a, input int stall_b, input int stall_len,
                       input int start_pulse_idx, input bit rand_valid,
                       output int cycles);
        int i;
        int pending;
        bit drove;
        i = 0;
        pending = 0;
        cycles = 0;
        sum_ready = 1'b0;
        if (do_start) begin
            start = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        while (i < 8) begin
            chk("in_ready_accum", {29'd0, ir0, ir1, ir2}, 32'd7);
            chk("sum_valid_early", {29'd0, sv0, sv1, sv2}, 32'd0);
            drove = 1'b0;
            start = 1'b0;
            if (pending > 0) begin
                in_valid = 1'b0;
                pending--;
            end else begin
                drove = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid = drove;
                in_bit = bits[i];
                if (drove && i == start_pulse_idx) start = 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (drove) begin
                i++;
                if (i == stall_a || i == stall_b) pending = stall_len;
            end
            if (cycles > 200) begin
                checks++;
                errors++;
                $error("FAIL run_timeout: observed=%0d cycles expected=<=200", cycles);
                break;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    // Output handshake for one cycle, optionally with a back-to-back START.
    task automatic release_sum(input bit next_start);
        sum_ready = 1'b1;
        start = next_start;
        @(negedge clk);
        sum_ready = 1'b0;
        start = 1'b0;
        chk("sum_valid_after_release", {29'd0, sv0, sv1, sv2}, 32'd0);
        chk("in_ready_after_release", {29'd0, ir0, ir1, ir2}, next_start ? 32'd7 : 32'd0);
    endtask

    initial begin
        int cyc;
        int ones;
        logic [7:0] bits;
        logic [3:0] held0;
        bit b2b;

        // Reset state while reset is held.
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic count: 1,0,1,1,0,0,1,1 -> 5.
        run(8'b1100_1101, 1'b1, -1, -1, 0, -1, 1'b0, cyc);
        chk("latency_nostall", 32'(cyc), 32'd9);
        check_result(5);
        release_sum(1'b0);

        // Same data, two-cycle stalls after bits 2 and 5: four extra cycles.
        run(8'b1100_1101, 1'b1, 2, 5, 2, -1, 1'b0, cyc);
        chk("latency_stall", 32'(cyc), 32'd13);
        check_result(5);
        release_sum(1'b0);

        // All ones: wrap vs saturate, overflow in the narrow instances.
        run(8'hFF, 1'b1, -1, -1, 0, -1, 1'b0, cyc);
        check_result(8);

        // Long HOLD: result must not move.
        held0 = sum0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", {29'd0, sv0, sv1, sv2}, 32'd7);
            chk("hold_sum_w4", 32'(sum0), 32'd8);
            chk("hold_sum_w2", {30'd0, sum1}, 32'd0);
            chk("hold_ovf", {29'd0, ov0, ov1, ov2}, 32'd3);
        end
        chk("hold_sum_w4_vs_entry", 32'(sum0), 32'(held0));

        // Back-to-back START clears overflow; a count of zeros follows.
        release_sum(1'b1);
        chk("b2b_ovf_cleared", {29'd0, ov0, ov1, ov2}, 32'd0);
        run(8'h00, 1'b0, -1, -1, 0, -1, 1'b0, cyc);
        chk("latency_b2b", 32'(cyc), 32'd8);
        check_result(0);
        release_sum(1'b0);

        // START pulsed during ACCUM after three ones is ignored.
        bits = 8'b1010_0111;
        run(bits, 1'b1, -1, -1, 0, 3, 1'b0, cyc);
        chk("latency_ignored_start", 32'(cyc), 32'd9);
        check_result($countones(bits));
        release_sum(1'b0);

        // Randomised counts with random valid gaps and consumer back-pressure.
        b2b = 1'b0;
        for (int n = 0; n < 16; n++) begin
            bits = 8'($urandom);
            ones = $countones(bits);
            run(bits, !b2b, -1, -1, 0, -1, 1'b1, cyc);
            check_result(ones);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rand_hold_valid", {29'd0, sv0, sv1, sv2}, 32'd7);
                chk("rand_hold_sum_w4", 32'(sum0), 32'(model_sum(ones, 4, 1'b0)));
            end
            b2b = 1'($urandom_range(0, 1));
            release_sum(b2b);
        end
        if (b2b) begin
            run(8'h00, 1'b0, -1, -1, 0, -1, 1'b0, cyc);
            check_result(0);
            release_sum(1'b0);
        end

        // Asynchronous reset mid-count after three ones.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        run(8'hFF, 1'b1, -1, -1, 0, -1, 1'b0, cyc);
        chk("latency_after_reset", 32'(cyc), 32'd9);
        check_result(8);
        release_sum(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
